// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, centre-sampling FSM, valid/ready byte output.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ftdi_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic          sync_0, sync_1;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          byte_done;
  logic          frame_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_err, par_err_n;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    byte_done = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!sync_1) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!sync_1) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {sync_1, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          par_err_n = ^{shift, sync_1};
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          frame_bad = !sync_1 || par_err;
`else
          frame_bad = !sync_1;
`endif
          byte_done = !frame_bad;
          // a low stop bit means the line may be held in break; wait for it to release
          state_n   = sync_1 ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (sync_1) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_0    <= 1'b1;
      sync_1    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      sync_0    <= ftdi_rx;
      sync_1    <= sync_0;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      frame_err <= frame_bad;
      overrun   <= byte_done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      par_err   <= par_err_n;
`endif
      // an accept in the completion cycle frees the slot, so the new byte is kept
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized frames
// compared against a frame-level model (expected byte queue and error count).
module tb_uart_rx;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int CLKS        = CLK_FREQ_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // 2 sync flops + 1 detect edge + half a bit + data/parity bits + stop bit
  localparam int LATENCY = 3 + CLKS / 2 + (9 + PB) * CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic       ftdi_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .ftdi_rx(ftdi_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int vcyc, fe_cnt, ov_cnt, unstable, rise_cyc;
  logic       prev_valid = 1'b0;
  logic       prev_acc   = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) vcyc++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid && prev_valid && !prev_acc && rx_data != prev_data) unstable++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
    prev_valid = rx_valid;
    prev_acc   = rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    ftdi_rx = b;
    repeat (CLKS) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) send_bit(1'b1);
`endif
    send_bit(stop_b);
  endtask

  task automatic clear_mon();
    vcyc = 0; fe_cnt = 0; ov_cnt = 0; unstable = 0; rise_cyc = -1;
    got_q.delete();
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int t0, gap, exp_fe;
    logic [7:0] d;
    logic bad_stop;

    ftdi_rx = 1'b1; rx_ready = 1'b0; reset = 1'b1;
    clear_mon();
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (5) tick();

    // 1: single byte, consumer always ready
    rx_ready = 1'b1; clear_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1);
    check("t1_latency", rise_cyc - t0, LATENCY);
    check("t1_count", got_q.size(), 1);
    check("t1_byte", q_at(0), 8'hA5);
    check("t1_vcyc", vcyc, 1);
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovr", ov_cnt, 0);

    // 2: consumer stalls, byte must stay put until accepted
    rx_ready = 1'b0; clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_bit(1'b1);
    repeat (50) tick();
    check("t2_valid_held", rx_valid, 1);
    check("t2_data_held", rx_data, 8'h3C);
    rx_ready = 1'b1;
    tick();
    check("t2_valid_clr", rx_valid, 0);
    check("t2_byte", q_at(0), 8'h3C);
    check("t2_stable", unstable, 0);

    // 3: second byte arrives before first is read
    rx_ready = 1'b0; clear_mon();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_bit(1'b1);
    check("t3_ovr", ov_cnt, 1);
    check("t3_data", rx_data, 8'h11);
    check("t3_valid", rx_valid, 1);
    rx_ready = 1'b1;
    repeat (3) tick();
    check("t3_count", got_q.size(), 1);
    check("t3_byte", q_at(0), 8'h11);

    // 4: bad stop bit followed by a long break
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0);
    ftdi_rx = 1'b0;
    repeat (30) tick();
    send_bit(1'b1);
    send_bit(1'b1);
    check("t4_ferr", fe_cnt, 1);
    check("t4_vcyc", vcyc, 0);
    clear_mon();
    send_frame(8'h0F, 1'b1, 1'b0);
    send_bit(1'b1);
    check("t4_next_byte", q_at(0), 8'h0F);
    check("t4_next_ferr", fe_cnt, 0);

    // 5: short glitch on idle line
    clear_mon();
    ftdi_rx = 1'b0;
    repeat (3) tick();
    ftdi_rx = 1'b1;
    repeat (30) tick();
    check("t5_vcyc", vcyc, 0);
    check("t5_ferr", fe_cnt, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    send_bit(1'b1);
    check("t5_after_byte", q_at(0), 8'hC3);

    // 6: reset in the middle of bit 4
    clear_mon();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * CLKS + 5) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 8'h00);
      end
    join
    send_bit(1'b1);
    check("t6_vcyc", vcyc, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1);
    check("t6_after_count", got_q.size(), 1);
    check("t6_after_byte", q_at(0), 8'h81);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check("par_bad_ferr", fe_cnt, 1);
    check("par_bad_count", got_q.size(), 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    check("par_ok_byte", q_at(0), 8'h07);
    check("par_ok_ferr", fe_cnt, 0);
`endif

    // 7: random frames with occasional stop errors and random gaps
    rx_ready = 1'b1; clear_mon();
    exp_q.delete(); exp_fe = 0;
    for (int n = 0; n < 24; n++) begin
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad_stop, 1'b0);
      if (bad_stop) exp_fe++;
      else exp_q.push_back(d);
      gap = bad_stop ? $urandom_range(2, 20) : $urandom_range(0, 20);
      ftdi_rx = 1'b1;
      repeat (gap) tick();
    end
    send_bit(1'b1);
    send_bit(1'b1);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("rand_byte", q_at(i), exp_q[i]);
    check("rand_ferr", fe_cnt, exp_fe);
    check("rand_ovr", ov_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
